// File: rtl/dshot_decoder.sv
// DSHOT150 line receiver: pulse-width bit decode, CRC check, error counting.
// Define DSHOT_DECODER_BIDIR_EN for the inverted line and inverted CRC.
`timescale 1ns/1ps
module dshot_decoder #(
    parameter int CLK_FREQ_HZ = 72000000,
    parameter int BIT_RATE    = 150000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_dshot,
    output logic [15:0] o_frame,
    output logic [10:0] o_throttle,
    output logic        o_telem,
    output logic        o_valid,
    output logic        o_crc_err,
    output logic        o_frame_err,
    output logic [7:0]  o_err_count,
    output logic        o_busy
);
    localparam int BIT_CYC = CLK_FREQ_HZ / BIT_RATE;
    localparam logic [16:0] THRESH = 17'(BIT_CYC * 9 / 16);
    localparam logic [16:0] MIN_H  = 17'(BIT_CYC / 8);
    localparam logic [16:0] MAX_H  = 17'(BIT_CYC * 7 / 8);
    localparam logic [16:0] GAP    = 17'(2 * BIT_CYC);

`ifdef DSHOT_DECODER_BIDIR_EN
    localparam logic IDLE_LVL = 1'b1;
    localparam logic CRC_INV  = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
    localparam logic CRC_INV  = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_CHECK
    } state_t;

    state_t      state, state_n;
    logic        sync1, sync2, prev;
    logic        act, rise;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic [16:0] len;
    logic [3:0]  idx, idx_n;
    logic [15:0] shreg, shreg_n;
    logic [15:0] frame_n;
    logic        valid_n, crc_err_n, ferr, busy_n;
    logic [11:0] v;
    logic [3:0]  crc_exp;
    logic        crc_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
            prev  <= IDLE_LVL;
        end else begin
            sync1 <= i_dshot;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign act  = sync2 ^ IDLE_LVL;
    assign rise = act & ~(prev ^ IDLE_LVL);

    // len counts the current cycle, so it equals the pulse length on its edge
    assign len     = {1'b0, cnt} + 17'd1;
    assign cnt_inc = (&cnt) ? cnt : cnt + 16'd1;

    assign v       = shreg[15:4];
    assign crc_exp = (v[3:0] ^ v[7:4] ^ v[11:8]) ^ {4{CRC_INV}};
    assign crc_ok  = (crc_exp == shreg[3:0]);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        frame_n   = o_frame;
        valid_n   = 1'b0;
        crc_err_n = 1'b0;
        ferr      = 1'b0;
        unique case (state)
            S_ARM: begin
                if (act) begin
                    cnt_n = '0;
                end else if (len >= GAP) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_IDLE: begin
                if (rise) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                    idx_n   = 4'd15;
                end
            end
            S_HIGH: begin
                if (act) begin
                    if (len >= MAX_H) ferr = 1'b1;
                    else cnt_n = cnt_inc;
                end else if (len < MIN_H || len > MAX_H) begin
                    ferr = 1'b1;
                end else begin
                    shreg_n = {shreg[14:0], len >= THRESH};
                    cnt_n   = '0;
                    state_n = (idx == 4'd0) ? S_CHECK : S_LOW;
                end
            end
            S_LOW: begin
                if (act) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                    idx_n   = idx - 4'd1;
                end else if (len >= GAP) begin
                    ferr = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_CHECK: begin
                if (crc_ok) begin
                    frame_n = shreg;
                    valid_n = 1'b1;
                end else begin
                    crc_err_n = 1'b1;
                end
                state_n = S_IDLE;
            end
            default: state_n = S_ARM;
        endcase
        if (ferr) begin
            state_n = S_ARM;
            cnt_n   = '0;
            shreg_n = '0;
        end
        busy_n = (state_n == S_HIGH) || (state_n == S_LOW) ||
                 (state_n == S_CHECK);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_ARM;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_frame     <= '0;
            o_valid     <= 1'b0;
            o_crc_err   <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_count <= '0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            o_frame     <= frame_n;
            o_valid     <= valid_n;
            o_crc_err   <= crc_err_n;
            o_frame_err <= ferr;
            o_busy      <= busy_n;
            if ((ferr || crc_err_n) && o_err_count != 8'hFF)
                o_err_count <= o_err_count + 8'd1;
        end
    end

    assign o_throttle = o_frame[15:5];
    assign o_telem    = o_frame[4];

endmodule

// File: doc/dshot_decoder.md
Name: dshot_decoder

Overview:
- Receives a DSHOT150 motor line and decodes it into 16-bit frames: 11-bit throttle, telemetry bit, 4-bit CRC.
- Receiver counterpart of the on-chip DSHOT transmitter. Used for loopback self-test from motor pin to decoder, and for sniffing an external flight-controller line.
- Checks the CRC and presents results as one-cycle strobes plus held registers, ready for a Wishbone status wrapper.

Parameters:
- CLK_FREQ_HZ, 72000000, system clock frequency.
- BIT_RATE, 150000, DSHOT bit rate in bit/s.
- Derived, not overridable:
  - BIT_CYC = CLK_FREQ_HZ/BIT_RATE (480).
  - THRESH_CYC = BIT_CYC*9/16 (270).
  - MIN_HIGH_CYC = BIT_CYC/8 (60).
  - MAX_HIGH_CYC = BIT_CYC*7/8 (420).
  - GAP_CYC = 2*BIT_CYC (960).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dshot  in  1  raw DSHOT line, asynchronous to i_clk.
- o_frame  out  16  last CRC-good frame.
- o_throttle  out  11  o_frame[15:5].
- o_telem  out  1  o_frame[4].
- o_valid  out  1  one-cycle strobe: o_frame updated.
- o_crc_err  out  1  one-cycle strobe: complete frame, CRC mismatch.
- o_frame_err  out  1  one-cycle strobe: framing error, frame aborted.
- o_err_count  out  8  saturating count of CRC and framing errors.
- o_busy  out  1  high while a frame is being received.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - All outputs 0; state ARM; counters 0; synchronizer flops set to the inactive line level.
- Input path:
  - 2-flop synchronizer, then a previous-sample register for edge detection.
  - Active level = 1.
  - All timing is measured on the synchronized signal.
- Counters:
  - 16-bit cycle counter, saturates at 0xFFFF.
  - 4-bit bit index.
  - 16-bit shift register, MSB received first.
- States:
  - ARM: wait for the line to sit inactive for ≥ GAP_CYC cycles, then go to IDLE. Prevents decoding from mid-frame after reset.
  - IDLE: active edge → HIGH, count cleared, bit index 15, o_busy=1.
  - HIGH: count while active.
    - Inactive edge with count < MIN_HIGH_CYC or > MAX_HIGH_CYC → framing error.
    - Otherwise shift in bit = (count ≥ THRESH_CYC).
    - If bit index was 0 → CHECK; else → LOW with count cleared.
    - Count reaches MAX_HIGH_CYC+1 while still active → framing error immediately.
  - LOW: count while inactive.
    - Active edge → HIGH, count cleared, bit index decremented.
    - Count reaches GAP_CYC → framing error.
  - CHECK (one cycle):
    - v = frame[15:4]; expected CRC = (v ^ v>>4 ^ v>>8) & 0xF.
    - Match → load o_frame, assert o_valid.
    - Mismatch → assert o_crc_err, o_frame unchanged.
    - Then → IDLE, o_busy=0.
  - Framing error: one-cycle o_frame_err pulse, o_busy=0, discard partial frame → ARM.
- Latency:
  - o_valid asserts 4 cycles after the raw falling edge of bit 0: 2 synchronizer cycles, edge-detect cycle, CHECK cycle.
- Output rules:
  - o_frame, o_throttle and o_telem hold until the next good frame.
  - At most one strobe per cycle.
  - o_err_count increments on either error strobe and saturates at 255, no wrap.
- Boundaries:
  - High exactly THRESH_CYC decodes as 1; THRESH_CYC-1 decodes as 0.
  - Back-to-back frames with minimum inter-frame gap (line inactive after CHECK, next active edge) are accepted without re-ARM.
  - Reset mid-frame forces ARM; no strobe emitted.

Optional Feature:
- Macro: DSHOT_DECODER_BIDIR_EN.
- Defined (bidirectional DSHOT):
  - Active level = 0; line idles high; synchronizer resets to 1.
  - Expected CRC is inverted: ~(v ^ v>>4 ^ v>>8) & 0xF.
- Undefined:
  - Normal polarity and normal CRC only, as described in Behaviour.

Test Plan:
- Reset with line low for 1000 cycles, then transmit throttle 48, telem 0 → o_valid pulse, o_frame=0x0606, o_throttle=48, o_telem=0, o_err_count=0.
- Throttle 1046, telem 1 (0x82D7) followed by 0x0606 with 1200-cycle gap → two o_valid pulses in order, final o_frame=0x0606.
- Frame 0x82D6 (bad CRC) → o_crc_err pulse, o_frame retains prior value, o_err_count=1.
- Bit high times of 269 and 270 cycles → decoded 0 and 1 respectively.
- Line held low 960 cycles after bit 7 → o_frame_err pulse, o_busy=0, no o_valid.
- Reset released mid-frame → first partial frame ignored, next full frame decoded.
- 300 bad frames → o_err_count saturates at 255.
- With DSHOT_DECODER_BIDIR_EN: inverted line carrying 0x82D8 → o_valid, o_frame=0x82D8; 0x82D7 → o_crc_err.
